// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_seq_pkg
// Purpose  : Shared types and constants for the PWM sequencer: FSM state
//            enum, step-table entry struct and the default table depth.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_seq_pkg;

    localparam int unsigned c_default_depth = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // period: frame length (0 encodes 256), pulse: high cycles per frame,
    // hold: frames per step (0 encodes 1).
    typedef struct packed {
        logic [7:0] period;
        logic [7:0] pulse;
        logic [7:0] hold;
    } step_t;

endpackage
`default_nettype wire

// File: rtl/pwm_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sequencer_if
// Purpose  : Step-table write channel (valid/ready plus one step entry).
// Ports    : wr_valid  - host write request
//            wr_ready  - table can accept a write
//            wr_period - frame length, 0 means 256
//            wr_pulse  - high cycles per frame
//            wr_hold   - frames per step, 0 means 1
// Modports : master (host side), slave (sequencer side)
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_sequencer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_period;
    logic [7:0] wr_pulse;
    logic [7:0] wr_hold;

    modport master (
        output wr_valid, wr_period, wr_pulse, wr_hold,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_period, wr_pulse, wr_hold,
        output wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/pwm_core.sv
`default_nettype none
// ============================================================================
// Module   : pwm_core
// Purpose  : 8-bit frame counter and pulse compare with a registered output.
// Ports    : i_clock, i_reset_n (async, active-low)
//            i_run       - block is running in the upcoming cycle
//            i_load      - latch i_period/i_pulse and restart the frame
//            i_period    - frame length, 0 means 256
//            i_pulse     - high cycles per frame
//            o_pwm       - registered PWM output
//            o_frame_end - current cycle is the last of its frame
// Revision : 1.0 - initial release
// ============================================================================
module pwm_core (
    input  wire logic       i_clock,
    input  wire logic       i_reset_n,
    input  wire logic       i_run,
    input  wire logic       i_load,
    input  wire logic [7:0] i_period,
    input  wire logic [7:0] i_pulse,
    output logic            o_pwm,
    output logic            o_frame_end
);
    logic [7:0] r_count;
    logic [7:0] r_period;
    logic [7:0] r_pulse;
    logic       r_run;
    logic       r_pwm;
    logic [7:0] w_count_next;
    logic [7:0] w_pulse_next;

    // 8-bit wrap makes period 0 end its frame at count 255.
    assign o_frame_end = r_run && (r_count == (r_period - 8'd1));

    // The output register is driven from the counter value it will sit next
    // to, so o_pwm and the counter always describe the same cycle.
    always_comb begin
        w_count_next = 8'd0;
        w_pulse_next = r_pulse;
        if (i_load) begin
            w_count_next = 8'd0;
            w_pulse_next = i_pulse;
        end else if (i_run && !o_frame_end) begin
            w_count_next = r_count + 8'd1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count  <= 8'd0;
            r_period <= 8'd0;
            r_pulse  <= 8'd0;
            r_run    <= 1'b0;
            r_pwm    <= 1'b0;
        end else begin
            r_run   <= i_run;
            r_count <= w_count_next;
            if (i_load) begin
                r_period <= i_period;
                r_pulse  <= i_pulse;
            end
            r_pwm <= i_run && (w_count_next < w_pulse_next);
        end
    end

    assign o_pwm = r_pwm;
endmodule
`default_nettype wire

// File: rtl/pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sequencer
// Purpose  : Plays back a table of (period, pulse, hold) steps on a PWM
//            output, changing steps only at frame boundaries.
// Ports    : i_clock, i_reset_n (async, active-low)
//            wr_bus   - step-table write channel (slave modport)
//            i_clear  - empty the table (IDLE only)
//            i_start  - begin playback (IDLE, non-empty table)
//            i_stop   - end playback at the next frame end
//            i_loop   - wrap to step 0 after the last step (latched at start)
//            o_pwm, o_busy, o_step, o_done
// Config   : PWM_SEQ_LOOP_EN - adds i_loop and the wrap-around behaviour;
//            without it playback is always one-shot.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int unsigned DEPTH = c_default_depth
) (
    input  wire logic                     i_clock,
    input  wire logic                     i_reset_n,
    pwm_sequencer_if.slave                wr_bus,
    input  wire logic                     i_clear,
    input  wire logic                     i_start,
    input  wire logic                     i_stop,
`ifdef PWM_SEQ_LOOP_EN
    input  wire logic                     i_loop,
`endif
    output logic                          o_pwm,
    output logic                          o_busy,
    output logic [$clog2(DEPTH)-1:0]      o_step,
    output logic                          o_done
);
    localparam int unsigned c_iw = $clog2(DEPTH);
    localparam int unsigned c_cw = c_iw + 1;

    state_t            r_state;
    state_t            w_state_next;
    step_t             r_table [DEPTH];
    logic [c_cw-1:0]   r_count;
    logic [c_iw-1:0]   r_step;
    logic [7:0]        r_hold;
    logic              r_stop;
    logic              r_done;
    logic              w_load;
    logic              w_end;
    logic              w_hold_dec;
    logic [c_iw-1:0]   w_load_idx;
    logic [c_cw-1:0]   w_next_idx;
    logic              w_wr_fire;
    logic              w_frame_end;
    logic              w_loop_wrap;
    step_t             w_entry;

`ifdef PWM_SEQ_LOOP_EN
    logic              r_loop;
    assign w_loop_wrap = r_loop;
`else
    assign w_loop_wrap = 1'b0;
`endif

    assign wr_bus.wr_ready = (r_state == ST_IDLE) && (r_count < c_cw'(DEPTH));
    // Clear takes priority over a write presented in the same cycle.
    assign w_wr_fire  = wr_bus.wr_valid && wr_bus.wr_ready && !i_clear;
    assign w_next_idx = {1'b0, r_step} + {{c_iw{1'b0}}, 1'b1};
    assign w_entry    = r_table[w_load_idx];

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_end        = 1'b0;
        w_hold_dec   = 1'b0;
        w_load_idx   = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && (r_count != '0)) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_frame_end) begin
                    // A stop seen on the frame-end cycle itself also ends here.
                    if (r_stop || i_stop) begin
                        w_end = 1'b1;
                    end else if (r_hold != 8'd1) begin
                        w_hold_dec = 1'b1;
                    end else if (w_next_idx < r_count) begin
                        w_load     = 1'b1;
                        w_load_idx = w_next_idx[c_iw-1:0];
                    end else if (w_loop_wrap) begin
                        w_load = 1'b1;
                    end else begin
                        w_end = 1'b1;
                    end
                    if (w_end) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_step  <= '0;
            r_hold  <= 8'd0;
            r_stop  <= 1'b0;
            r_done  <= 1'b0;
`ifdef PWM_SEQ_LOOP_EN
            r_loop  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_done  <= w_end;

            if ((r_state == ST_IDLE) && i_clear) begin
                r_count <= '0;
            end else if (w_wr_fire) begin
                r_count <= r_count + {{c_iw{1'b0}}, 1'b1};
            end

            if (w_end) begin
                r_step <= '0;
            end else if (w_load) begin
                r_step <= w_load_idx;
            end

            if (w_load) begin
                r_hold <= (w_entry.hold == 8'd0) ? 8'd1 : w_entry.hold;
            end else if (w_hold_dec) begin
                r_hold <= r_hold - 8'd1;
            end

            if ((r_state == ST_IDLE) || w_end) begin
                r_stop <= 1'b0;
            end else if (i_stop) begin
                r_stop <= 1'b1;
            end

`ifdef PWM_SEQ_LOOP_EN
            if ((r_state == ST_IDLE) && w_load) begin
                r_loop <= i_loop;
            end
`endif
        end
    end

    // Table storage needs no reset: validity is tracked by r_count alone.
    always_ff @(posedge i_clock) begin
        if (w_wr_fire) begin
            r_table[r_count[c_iw-1:0]] <= '{period: wr_bus.wr_period,
                                            pulse:  wr_bus.wr_pulse,
                                            hold:   wr_bus.wr_hold};
        end
    end

    pwm_core u_core (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_run       (w_state_next == ST_RUN),
        .i_load      (w_load),
        .i_period    (w_entry.period),
        .i_pulse     (w_entry.pulse),
        .o_pwm       (o_pwm),
        .o_frame_end (w_frame_end)
    );

    assign o_busy = (r_state == ST_RUN);
    assign o_step = r_step;
    assign o_done = r_done;
endmodule
`default_nettype wire

// File: tb/tb_pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_sequencer
// Purpose  : Self-checking bench for pwm_sequencer. A behavioural model
//            expands the written table into the expected per-cycle output
//            trace (pwm, step) and truncates it at the frame that a stop
//            request lands in.
// Config   : PWM_SEQ_LOOP_EN - enables the loop-mode scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_sequencer;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       start;
    logic       stop;
`ifdef PWM_SEQ_LOOP_EN
    logic       loop_i;
`endif
    logic       pwm;
    logic       busy;
    logic       done;
    logic [2:0] step;

    int total = 0;
    int bad   = 0;

    // Behavioural table model
    int m_per [DEPTH];
    int m_pul [DEPTH];
    int m_hld [DEPTH];
    int m_count = 0;

    // Expected trace, one element per cycle of playback
    int e_pwm  [$];
    int e_step [$];
    bit e_fe   [$];

    pwm_sequencer_if bus ();

    always #5 clk = ~clk;

    pwm_sequencer #(.DEPTH(DEPTH)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .wr_bus    (bus.slave),
        .i_clear   (clear),
        .i_start   (start),
        .i_stop    (stop),
`ifdef PWM_SEQ_LOOP_EN
        .i_loop    (loop_i),
`endif
        .o_pwm     (pwm),
        .o_busy    (busy),
        .o_step    (step),
        .o_done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input int pl, input int h);
        check("wr_ready", {31'd0, bus.wr_ready}, {31'd0, (m_count < DEPTH)});
        bus.wr_valid  = 1'b1;
        bus.wr_period = p[7:0];
        bus.wr_pulse  = pl[7:0];
        bus.wr_hold   = h[7:0];
        tick();
        bus.wr_valid  = 1'b0;
        if (m_count < DEPTH) begin
            m_per[m_count] = p;
            m_pul[m_count] = pl;
            m_hld[m_count] = h;
            m_count++;
        end
    endtask

    // Clear together with a write: the clear must win.
    task automatic do_clear();
        clear = 1'b1;
        bus.wr_valid = 1'b1;
        tick();
        clear = 1'b0;
        bus.wr_valid = 1'b0;
        m_count = 0;
        check("clr_ready", {31'd0, bus.wr_ready}, 32'd1);
    endtask

    task automatic build_trace(input int reps);
        int plen;
        int hcnt;
        e_pwm.delete();
        e_step.delete();
        e_fe.delete();
        for (int r = 0; r < reps; r++) begin
            for (int s = 0; s < m_count; s++) begin
                plen = (m_per[s] == 0) ? 256 : m_per[s];
                hcnt = (m_hld[s] == 0) ? 1 : m_hld[s];
                for (int f = 0; f < hcnt; f++) begin
                    for (int c = 0; c < plen; c++) begin
                        e_pwm.push_back((c < m_pul[s]) ? 1 : 0);
                        e_step.push_back(s);
                        e_fe.push_back(c == plen - 1);
                    end
                end
            end
        end
    endtask

    // stop_k: -1 none, -2 random, else trace index whose cycle carries i_stop.
    task automatic play(input int stop_k_in, input int reps, input bit loop_v, input bit poke);
        int stop_k;
        int j;
        logic [5:0] exp_v;
        build_trace(reps);
        stop_k = stop_k_in;
        if (stop_k == -2) begin
            stop_k = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, e_pwm.size() - 1));
        end
        if (stop_k >= 0) begin
            j = stop_k;
            while (!e_fe[j]) j++;
            while (e_pwm.size() > j + 1) begin
                void'(e_pwm.pop_back());
                void'(e_step.pop_back());
                void'(e_fe.pop_back());
            end
        end
`ifdef PWM_SEQ_LOOP_EN
        loop_i = loop_v;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef PWM_SEQ_LOOP_EN
        loop_i = ~loop_v;
`endif
        for (int k = 0; k < e_pwm.size(); k++) begin
            exp_v = {1'b0, 1'b1, 3'(e_step[k]), 1'(e_pwm[k])};
            check("trace", {26'd0, done, busy, step, pwm}, {26'd0, exp_v});
            if (k == 0) check("run_ready", {31'd0, bus.wr_ready}, 32'd0);
            if (poke && k == 1) begin
                bus.wr_valid = 1'b1;
                clear = 1'b1;
                start = 1'b1;
            end else begin
                bus.wr_valid = 1'b0;
                clear = 1'b0;
                start = 1'b0;
            end
            stop = (k == stop_k);
            tick();
        end
        stop = 1'b0;
        bus.wr_valid = 1'b0;
        clear = 1'b0;
        start = 1'b0;
        check("end", {26'd0, done, busy, step, pwm}, {26'd0, 6'b100000});
        check("end_ready", {31'd0, bus.wr_ready}, {31'd0, (m_count < DEPTH)});
        tick();
        check("post_end", {26'd0, done, busy, step, pwm}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
`ifdef PWM_SEQ_LOOP_EN
        loop_i = 1'b0;
`endif
        bus.wr_valid  = 1'b0;
        bus.wr_period = 8'd0;
        bus.wr_pulse  = 8'd0;
        bus.wr_hold   = 8'd0;
        tick();
        check("rst_pwm",   {31'd0, pwm},  32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_step",  {29'd0, step}, 32'd0);
        check("rst_ready", {31'd0, bus.wr_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Single step, two frames
        wr(4, 1, 2);
        play(-1, 1, 1'b0, 1'b0);

        // Two-step transition; table is retained so it can be replayed
        do_clear();
        wr(4, 2, 1);
        wr(3, 3, 1);
        play(-1, 1, 1'b0, 1'b1);
        play(-1, 1, 1'b0, 1'b0);

        // Edge encodings
        do_clear();
        wr(0, 255, 0);
        wr(5, 0, 1);
        wr(5, 9, 1);
        play(-1, 1, 1'b0, 1'b0);

        // Start with an empty table is ignored
        do_clear();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty_start", {31'd0, busy}, 32'd0);

        // Full table, extra write dropped
        for (int i = 0; i < DEPTH; i++) begin
            wr(int'($urandom_range(1, 6)), int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end
        check("full_ready", {31'd0, bus.wr_ready}, 32'd0);
        wr(7, 7, 7);
        play(-1, 1, 1'b0, 1'b1);

        // Stop mid-frame and coincident with a frame end
        do_clear();
        wr(8, 3, 10);
        play(10, 1, 1'b0, 1'b0);
        play(15, 1, 1'b0, 1'b0);

`ifdef PWM_SEQ_LOOP_EN
        do_clear();
        wr(3, 1, 1);
        wr(2, 1, 1);
        play(11, 4, 1'b1, 1'b0);
`endif

        // Randomized tables and stops
        for (int it = 0; it < 20; it++) begin
            int n;
            do_clear();
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                wr(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9)),
                   int'($urandom_range(0, 10)), int'($urandom_range(0, 3)));
            end
            play(-2, 1, 1'b0, it[0]);
        end

        // Asynchronous reset during playback
        do_clear();
        wr(10, 5, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out", {26'd0, done, busy, step, pwm}, 32'd0);
        check("arst_ready", {31'd0, bus.wr_ready}, 32'd1);
        rst_n = 1'b1;
        m_count = 0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("arst_count0", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pwm_sequencer.md
# pwm_sequencer

Programmable PWM sequencer: a small step table holds (period, pulse, hold) entries. Once started, the block plays them back on its own PWM output. Each step lasts `hold` complete PWM frames. Step changes happen only at frame boundaries, so the output never glitches. It sits between the register/host side, which loads the table, and the pad-level PWM output, and replaces direct static period/pulse drive of the plain generator.

## Interface
- `DEPTH`, 8: step table entries (power of two, 2..16).
- `i_clock`  in  1  clock; all state changes on rising edge.
- `i_reset_n`  in  1  reset, asynchronous assert, active-low.
- `i_wr_valid`  in  1  table write request.
- `o_wr_ready`  out  1  table can accept a write.
- `i_wr_period`  in  8  frame length in cycles; 0 means 256.
- `i_wr_pulse`  in  8  high cycles per frame; values at or above the frame length mean constant high.
- `i_wr_hold`  in  8  frames per step; 0 means 1.
- `i_clear`  in  1  empty the table (IDLE only).
- `i_start`  in  1  begin playback (IDLE only).
- `i_stop`  in  1  request graceful stop.
- `i_loop`  in  1  wrap to step 0 after the last step (only with `PWM_SEQ_LOOP_EN`).
- `o_pwm`  out  1  registered PWM output.
- `o_busy`  out  1  state is RUN.
- `o_step`  out  $clog2(DEPTH)  index of the active step.
- `o_done`  out  1  one-cycle pulse when playback ends.

## Operation
- States:
  - IDLE: table writable; o_pwm=0.
  - RUN: playing back.
- Table write:
  - A write occurs when `i_wr_valid && o_wr_ready`. The entry goes to index `count`, and `count` increments.
  - `o_wr_ready = (state==IDLE) && (count<DEPTH)`.
- `i_clear` in IDLE sets `count=0`. It wins over a same-cycle write. It is ignored in RUN.
- `i_start`:
  - In IDLE with count>0: load entry 0 into the active registers, counter=0, remaining hold = hold0 (0 becomes 1), latch `i_loop`, go to RUN.
  - With count=0: ignored.
  - In RUN: ignored.
- RUN frame behaviour:
  - 8-bit counter runs 0..P-1, where P=256 when period=0.
  - `o_pwm` = counter < pulse.
  - Frame end is counter==P-1 (8-bit compare, so 255 when period=0).
- At each frame end:
  - Decrement the remaining hold.
  - If it reaches 0, advance to the next step.
- Advance:
  - If the next index < count: load that entry.
  - Otherwise, if loop is latched: load entry 0.
  - Otherwise: end playback.
- End of playback: go to IDLE, pulse `o_done`, o_step=0, table contents and count retained.
- `i_stop`:
  - In RUN it sets a sticky stop flag. Playback ends at the next frame end, regardless of remaining hold.
  - If stop is asserted in the same cycle as a frame end, that frame end is the end.
  - In IDLE, `i_stop` is ignored.
- Reset mid-playback: immediate return to the reset state below; the table is invalidated (count=0).

## Timing
- Reset values:
  - Outputs: o_pwm=0, o_busy=0, o_done=0, o_step=0, o_wr_ready=1.
  - Internal: count=0, stop flag=0, state IDLE.
- All outputs are registered except `o_wr_ready` (decoded from registered state/count).
- `o_pwm` at edge k reflects the counter value held after edge k.
- Start: `i_start` sampled at edge N. Then o_busy=1, counter=0 and o_pwm=(pulse0>0) after edge N.
- Step change: the frame-end cycle of the old step is its last. After the next edge, counter=0, the new pulse applies, and o_step updates.
- End: after the final frame-end edge, state=IDLE, o_pwm=0, o_busy=0 and o_done=1 for exactly one cycle. o_wr_ready=1 in that same cycle if count<DEPTH.
- Write latency 1: an entry written at edge N is startable by `i_start` at edge N+1.

## Configuration
- `PWM_SEQ_LOOP_EN` defined:
  - `i_loop` port exists.
  - Its value is latched at start and selects wrap-to-step-0 versus end-after-last-step.
- Not defined:
  - No `i_loop` port; playback is always one-shot.
  - Loop-related logic is removed.

## Structure
- `pwm_seq_pkg`:
  - State enum (IDLE, RUN).
  - Step struct typedef {period, pulse, hold}, each 8 bits.
  - Default DEPTH constant.
- Sub-module `pwm_core`:
  - 8-bit counter and compare.
  - Inputs: run, load strobe, period, pulse.
  - Outputs: pwm and frame_end.
  - Load resets the counter to 0.
- The sequencer FSM, step table and hold counter live in `pwm_sequencer`.

## Test plan
- One step, then end: write {P=4, pulse=1, hold=2}, start → o_pwm 1,0,0,0,1,0,0,0. Then o_done pulses once, o_busy=0, o_pwm=0.
- Two-step transition: {4,2,1} then {3,3,1} → o_pwm 1,1,0,0,1,1,1. o_step changes 0→1 exactly at the frame boundary. No short or extra pulse.
- Edge encodings:
  - {period=0, pulse=255, hold=0}: 256-cycle frame, 255 high cycles, one frame.
  - {P=5, pulse=0}: all low.
  - {P=5, pulse=9}: all high.
- Table full and clear: write DEPTH entries → o_wr_ready=0 and the 9th write is dropped. `i_clear` with `i_wr_valid` in the same cycle → count=0, o_wr_ready=1. Writes and clear during RUN are ignored.
- Stop:
  - {P=8, hold=10}: `i_stop` in cycle 3 of frame 2 → ends at that frame's end.
  - `i_stop` coincident with a frame end → ends at that edge.
  - In both cases, exactly one o_done.
- Loop (with macro): 2 entries, i_loop=1 → o_step 0,1,0,1 until i_stop; mid-run changes of i_loop are ignored. Async reset mid-RUN → all outputs at reset values immediately; count=0.
